// File: rtl/srec_txn_pkg.sv
// Shared types and constants for the SREC write-transaction sequencer:
// default widths, the sequencer state encoding, the status bundle and a
// width helper used to size the retry and timeout counters.
package srec_txn_pkg;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_ISSUE        = 3'd1,
        ST_WAIT         = 3'd2,
        ST_VERIFY_ISSUE = 3'd3,
        ST_VERIFY_WAIT  = 3'd4,
        ST_FAULT        = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic                  err;
        logic [DEF_ADDR_W-1:0] err_addr;
        logic [DEF_CNT_W-1:0]  word_cnt;
    } seq_status_t;

    // Number of bits needed to hold any value in 0..value (at least 1).
    function automatic int bits_for(input int value);
        int w;
        w = 1;
        while ((1 << w) <= value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/srec_txn_sequencer_if.sv
// Bus bundle between the SREC parser, the sequencer, the M01_AXI transaction
// engine and boot control. The master modport is the sequencer's view; the
// slave modport is the view of everything around it.
interface srec_txn_sequencer_if
    import srec_txn_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_last;

    logic              txn_init;
    logic              txn_wr;
    logic [ADDR_W-1:0] txn_addr;
    logic [DATA_W-1:0] txn_wdata;
    logic              txn_done;
    logic              txn_error;
    logic [DATA_W-1:0] txn_rdata;

    logic              clear_err;
    logic              busy;
    logic              blk_done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;
    logic [CNT_W-1:0]  word_cnt;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, cmd_last,
        output cmd_ready,
        output txn_init, txn_wr, txn_addr, txn_wdata,
        input  txn_done, txn_error, txn_rdata,
        input  clear_err,
        output busy, blk_done, err, err_addr, word_cnt
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, cmd_last,
        input  cmd_ready,
        input  txn_init, txn_wr, txn_addr, txn_wdata,
        output txn_done, txn_error, txn_rdata,
        output clear_err,
        input  busy, blk_done, err, err_addr, word_cnt
    );

endinterface

// File: rtl/srec_txn_timeout.sv
// Attempt watchdog: a loadable down-counter. Loading starts a wait window,
// enable counts it down, and o_expire flags that the window has run out.
// Clear parks the counter at zero while no attempt is outstanding.
module srec_txn_timeout
    import srec_txn_pkg::*;
#(
    parameter int          WIDTH    = 10,
    parameter int unsigned LOAD_VAL = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [WIDTH-1:0] LOAD = WIDTH'(LOAD_VAL);

    logic [WIDTH-1:0] r_count;

    // Count down from the load value once per enabled cycle, stopping at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = (r_count == '0);

endmodule

// File: rtl/srec_txn_sequencer.sv
// SREC boot loader write sequencer. Accepts decoded record words from the
// parser, issues one single-beat AXI write per word through the transaction
// engine, retries failed attempts, latches a sticky fault with the failing
// address, and reports block completion and the count of words written.
// Optional read-back verify of every write is built when the macro
// SREC_TXN_SEQ_VERIFY_EN is defined; by default only writes are issued.
module srec_txn_sequencer
    import srec_txn_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    srec_txn_sequencer_if.master bus
);

    localparam int RETRY_W = bits_for(MAX_RETRY);
    localparam int TMR_W   = bits_for(TIMEOUT_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    seq_state_t        r_state;
    seq_state_t        w_next_state;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_last;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
    logic              r_blk_done;

    logic              w_accept;
    logic              w_tmr_clear;
    logic              w_tmr_load;
    logic              w_tmr_en;
    logic              w_tmr_expire;
    logic              w_word_ok;
    logic              w_attempt_fail;
    logic              w_can_retry;
    logic              w_fault_clear;

    assign w_can_retry   = (r_retry_cnt < RETRY_LIMIT);
    assign w_tmr_clear   = (r_state == ST_IDLE) || (r_state == ST_FAULT);
    assign w_fault_clear = (r_state == ST_FAULT) && bus.clear_err;

    srec_txn_timeout #(
        .WIDTH    (TMR_W),
        .LOAD_VAL (TIMEOUT_CYC - 1)
    ) u_timeout (
        .clk      (ACLK),
        .rst      (ARESET),
        .i_clear  (w_tmr_clear),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .o_expire (w_tmr_expire)
    );

    // State register; a reset in any state abandons the attempt in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state plus the per-cycle strobes that steer the datapath; a
    // completion that coincides with the timeout is treated as a completion.
    always_comb begin
        w_next_state   = r_state;
        w_accept       = 1'b0;
        w_tmr_load     = 1'b0;
        w_tmr_en       = 1'b0;
        w_word_ok      = 1'b0;
        w_attempt_fail = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                w_tmr_load   = 1'b1;
                w_next_state = ST_WAIT;
            end

            ST_WAIT: begin
                w_tmr_en = 1'b1;
                if (bus.txn_done) begin
                    if (!bus.txn_error) begin
`ifdef SREC_TXN_SEQ_VERIFY_EN
                        w_next_state = ST_VERIFY_ISSUE;
`else
                        w_word_ok = 1'b1;
`endif
                    end else begin
                        w_attempt_fail = 1'b1;
                    end
                end else if (w_tmr_expire) begin
                    w_attempt_fail = 1'b1;
                end
            end

`ifdef SREC_TXN_SEQ_VERIFY_EN
            ST_VERIFY_ISSUE: begin
                w_tmr_load   = 1'b1;
                w_next_state = ST_VERIFY_WAIT;
            end

            ST_VERIFY_WAIT: begin
                w_tmr_en = 1'b1;
                if (bus.txn_done) begin
                    if (!bus.txn_error && (bus.txn_rdata == r_data)) begin
                        w_word_ok = 1'b1;
                    end else begin
                        w_attempt_fail = 1'b1;
                    end
                end else if (w_tmr_expire) begin
                    w_attempt_fail = 1'b1;
                end
            end
`endif

            ST_FAULT: begin
                if (bus.clear_err) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_word_ok) begin
            w_next_state = ST_IDLE;
        end

        if (w_attempt_fail) begin
            w_next_state = w_can_retry ? ST_ISSUE : ST_FAULT;
        end
    end

    // Word latch, retry budget, saturating success count, block pulse and fault capture.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_retry_cnt <= '0;
            r_word_cnt  <= '0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
            r_blk_done  <= 1'b0;
        end else begin
            r_blk_done <= 1'b0;

            if (w_accept) begin
                r_addr      <= bus.cmd_addr;
                r_data      <= bus.cmd_data;
                r_last      <= bus.cmd_last;
                r_retry_cnt <= '0;
            end

            if (w_word_ok) begin
                if (r_word_cnt != '1) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
                r_blk_done <= r_last;
            end

            if (w_attempt_fail) begin
                if (w_can_retry) begin
                    r_retry_cnt <= r_retry_cnt + 1'b1;
                end else begin
                    r_err      <= 1'b1;
                    r_err_addr <= r_addr;
                end
            end

            if (w_fault_clear) begin
                r_err      <= 1'b0;
                r_err_addr <= '0;
            end
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.txn_addr  = r_addr;
    assign bus.txn_wdata = r_data;
    assign bus.blk_done  = r_blk_done;
    assign bus.err       = r_err;
    assign bus.err_addr  = r_err_addr;
    assign bus.word_cnt  = r_word_cnt;

`ifdef SREC_TXN_SEQ_VERIFY_EN
    assign bus.txn_init = (r_state == ST_ISSUE) || (r_state == ST_VERIFY_ISSUE);
    assign bus.txn_wr   = (r_state == ST_ISSUE);
`else
    logic w_unused_rdata;

    assign bus.txn_init   = (r_state == ST_ISSUE);
    assign bus.txn_wr     = 1'b1;
    assign w_unused_rdata = ^bus.txn_rdata;
`endif

endmodule
